// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: FSM state encoding, protocol limits
// and the bit-timing derivation used by the sampler and its bit timer.
package can_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE,
        ST_IDLE,
        ST_SOF_BIT,
        ST_RECEIVE
    } can_state_e;

    localparam int unsigned STUFF_LIMIT = 5;
    localparam int unsigned IDLE_BITS   = 11;

    function automatic int unsigned calc_bit_cnt(input int unsigned clk_mhz,
                                                 input int unsigned kbps);
        return (clk_mhz * 1000) / kbps;
    endfunction

    function automatic int unsigned calc_sample_cnt(input int unsigned bit_cnt,
                                                    input int unsigned pct);
        return (bit_cnt * pct) / 100;
    endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Free-running CAN bit-time counter with hard sync; flags the sample point.
module can_bit_timer #(
    parameter int unsigned BIT_CNT    = 100,
    parameter int unsigned SAMPLE_CNT = 75
) (
    input  logic clk,
    input  logic rst,
    input  logic hard_sync_i,
    output logic sample_tick_o
);

    localparam int unsigned CNT_W = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (hard_sync_i || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A hard sync landing on the sample point suppresses that sample.
    assign sample_tick_o = (cnt_q == SAMPLE_LAST) && !hard_sync_i;

endmodule

// File: rtl/can_bit_sampler.sv
// CAN receive front end: synchronizes rx, tracks bus idle / SOF, samples each
// bit at the sample point and removes stuff bits before handing bits on.
module can_bit_sampler
    import can_pkg::*;
#(
    parameter int unsigned clk_speed_MHz      = 100,
    parameter int unsigned can_bit_rate_Kbits = 1000,
    parameter int unsigned sample_point_pct   = 75
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic sample_en,
    input  logic stuff_en,
    output logic din,
    output logic dvalid,
    output logic sof,
    output logic stuff_error,
    output logic bus_idle
);

    localparam int unsigned BIT_CNT    = calc_bit_cnt(clk_speed_MHz, can_bit_rate_Kbits);
    localparam int unsigned SAMPLE_CNT = calc_sample_cnt(BIT_CNT, sample_point_pct);
    localparam logic [3:0]  IDLE_LAST  = 4'(IDLE_BITS - 1);
    localparam logic [2:0]  STUFF_MAX  = 3'(STUFF_LIMIT);

    can_state_e  state_q, state_d;
    logic        rx_meta_q, rx_sync_q, rx_d_q;
    logic [3:0]  integ_q, integ_d;
    logic        run_val_q, run_val_d;
    logic [2:0]  run_len_q, run_len_d;
    logic        en_seen_q, en_seen_d;
    logic [1:0]  samp_n_q, samp_n_d;
    logic        din_q, din_d;
    logic        dvalid_q, dvalid_d;
    logic        sof_q, sof_d;
    logic        serr_q, serr_d;
    logic        idle_q, idle_d;
    logic        fall_edge;
    logic        sample_tick;
    logic        en_now;

    assign fall_edge = !rx_sync_q && rx_d_q;

    can_bit_timer #(
        .BIT_CNT    (BIT_CNT),
        .SAMPLE_CNT (SAMPLE_CNT)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .hard_sync_i   (fall_edge),
        .sample_tick_o (sample_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_d_q    <= rx_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        integ_d   = integ_q;
        run_val_d = run_val_q;
        run_len_d = run_len_q;
        en_seen_d = en_seen_q;
        samp_n_d  = samp_n_q;
        din_d     = din_q;
        dvalid_d  = 1'b0;
        sof_d     = 1'b0;
        serr_d    = 1'b0;
        en_now    = en_seen_q || sample_en;

        unique case (state_q)
            ST_INTEGRATE: begin
                if (sample_tick) begin
                    if (!rx_sync_q) begin
                        integ_d = '0;
                    end else if (integ_q == IDLE_LAST) begin
                        integ_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        integ_d = integ_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d = ST_SOF_BIT;
                end
            end
            ST_SOF_BIT: begin
                if (sample_tick) begin
                    if (!rx_sync_q) begin
                        sof_d     = 1'b1;
                        dvalid_d  = 1'b1;
                        din_d     = 1'b0;
                        run_val_d = 1'b0;
                        run_len_d = 3'd1;
                        en_seen_d = 1'b0;
                        samp_n_d  = '0;
                        state_d   = ST_RECEIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RECEIVE: begin
                if (sample_en) begin
                    en_seen_d = 1'b1;
                end
                if (en_seen_q && !sample_en) begin
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    if (samp_n_q != 2'd2) begin
                        samp_n_d = samp_n_q + 2'd1;
                    end
                    // No consumer claimed the frame by its second data sample.
                    if (samp_n_q == 2'd1 && !en_now) begin
                        state_d = ST_IDLE;
                    end else if (stuff_en && run_len_q == STUFF_MAX) begin
                        if (rx_sync_q != run_val_q) begin
                            run_val_d = rx_sync_q;
                            run_len_d = 3'd1;
                        end else begin
                            serr_d  = 1'b1;
                            integ_d = '0;
                            state_d = ST_INTEGRATE;
                        end
                    end else begin
                        dvalid_d = 1'b1;
                        din_d    = rx_sync_q;
                        if (stuff_en && rx_sync_q == run_val_q) begin
                            if (run_len_q != STUFF_MAX) begin
                                run_len_d = run_len_q + 3'd1;
                            end
                        end else begin
                            run_val_d = rx_sync_q;
                            run_len_d = 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INTEGRATE;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INTEGRATE;
            integ_q   <= '0;
            run_val_q <= 1'b1;
            run_len_q <= '0;
            en_seen_q <= 1'b0;
            samp_n_q  <= '0;
            din_q     <= 1'b1;
            dvalid_q  <= 1'b0;
            sof_q     <= 1'b0;
            serr_q    <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            integ_q   <= integ_d;
            run_val_q <= run_val_d;
            run_len_q <= run_len_d;
            en_seen_q <= en_seen_d;
            samp_n_q  <= samp_n_d;
            din_q     <= din_d;
            dvalid_q  <= dvalid_d;
            sof_q     <= sof_d;
            serr_q    <= serr_d;
            idle_q    <= idle_d;
        end
    end

    assign din         = din_q;
    assign dvalid      = dvalid_q;
    assign sof         = sof_q;
    assign stuff_error = serr_q;
    assign bus_idle    = idle_q;

endmodule

// File: tb/tb_can_bit_sampler.sv
// Scoreboard bench for can_bit_sampler at default timing (100 MHz, 1 Mbit/s).
module tb_can_bit_sampler;

    typedef struct {
        logic din;
        logic sof;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rx, sample_en, stuff_en;
    logic din, dvalid, sof, stuff_error, bus_idle;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   sof_cnt = 0;
    int   err_cnt = 0;
    int   err_cyc = 0;
    exp_t exp_q[$];
    int   dv_t[$];

    can_bit_sampler #(
        .clk_speed_MHz      (100),
        .can_bit_rate_Kbits (1000),
        .sample_point_pct   (75)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .sample_en   (sample_en),
        .stuff_en    (stuff_en),
        .din         (din),
        .dvalid      (dvalid),
        .sof         (sof),
        .stuff_error (stuff_error),
        .bus_idle    (bus_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pops one expectation per delivered bit.
    always @(posedge clk) begin
        #1;
        if (sof) sof_cnt++;
        if (stuff_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (dvalid) begin
            dv_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_dvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("din", din, e.din);
                check("sof", sof, e.sof);
            end
        end
    end

    // Caller sits on a negedge; each bit lasts one bit time.
    task automatic drive_bit(input logic b, input logic expect_it, input logic is_sof);
        exp_t e;
        rx = b;
        if (expect_it) begin
            e.din = b;
            e.sof = is_sof;
            exp_q.push_back(e);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_idle) break;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int te;
        int s0;
        logic [7:0] bits;
        logic [7:0] keep;

        rst = 1'b1; rx = 1'b1; sample_en = 1'b0; stuff_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din", din, 1'b1);
        check("rst_dvalid", dvalid, 1'b0);
        check("rst_sof", sof, 1'b0);
        check("rst_stuff_error", stuff_error, 1'b0);
        check("rst_bus_idle", bus_idle, 1'b0);

        // 11 recessive samples: 11th sample point is counter 74 of bit 11.
        @(negedge clk);
        rst = 1'b0;
        wait_idle(1500, n);
        check("idle_rise_cycle", n, 1075);
        check("idle_no_dvalid", dv_t.size(), 0);

        // 300 ns dominant glitch.
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_sof", sof_cnt, 0);
        check("glitch_bus_idle", bus_idle, 1'b1);
        check("glitch_no_dvalid", dv_t.size(), 0);

        // Plain frame 0,1,1,0,1 without destuffing.
        dv_t.delete();
        s0 = sof_cnt;
        te = cyc + 1;
        bits = 8'b1011_0110;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) sample_en = 1'b1;
            drive_bit(bits[i], 1'b1, i == 0);
        end
        sample_en = 1'b0;
        repeat (20) @(negedge clk);
        check("frame_sof_cnt", sof_cnt - s0, 1);
        check("frame_dv_cnt", dv_t.size(), 5);
        for (int i = 0; i < 5 && i < dv_t.size(); i++) begin
            check("frame_dv_time", dv_t[i], te + 77 + 100 * i);
        end
        check("frame_end_idle", bus_idle, 1'b1);
        check("frame_q_empty", exp_q.size(), 0);

        // Five ones, stuff 0 dropped, then a 1.
        dv_t.delete();
        stuff_en = 1'b1;
        bits = 8'b1011_1110;
        keep = 8'b1011_1111;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) sample_en = 1'b1;
            drive_bit(bits[i], keep[i], i == 0);
        end
        sample_en = 1'b0;
        stuff_en = 1'b0;
        repeat (20) @(negedge clk);
        check("stuff_dv_cnt", dv_t.size(), 7);
        check("stuff_no_error", err_cnt, 0);
        check("stuff_q_empty", exp_q.size(), 0);
        check("stuff_end_idle", bus_idle, 1'b1);

        // Six dominant bits from SOF: violation at the 6th sample.
        dv_t.delete();
        stuff_en = 1'b1;
        te = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) sample_en = 1'b1;
            drive_bit(1'b0, i < 5, i == 0);
        end
        rx = 1'b1;
        sample_en = 1'b0;
        stuff_en = 1'b0;
        check("serr_cnt", err_cnt, 1);
        check("serr_time", err_cyc, te + 77 + 500);
        check("serr_dv_cnt", dv_t.size(), 5);
        check("serr_bus_idle_low", bus_idle, 1'b0);
        repeat (1000) @(negedge clk);
        check("serr_idle_after_10", bus_idle, 1'b0);
        repeat (100) @(negedge clk);
        check("serr_idle_after_11", bus_idle, 1'b1);
        check("serr_q_empty", exp_q.size(), 0);

        // Reset mid-frame, then a new SOF must be ignored.
        dv_t.delete();
        s0 = sof_cnt;
        drive_bit(1'b0, 1'b1, 1'b1);
        sample_en = 1'b1;
        drive_bit(1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("pre_rst_din", din, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_din", din, 1'b1);
        check("midrst_dvalid", dvalid, 1'b0);
        check("midrst_sof", sof, 1'b0);
        check("midrst_stuff_error", stuff_error, 1'b0);
        check("midrst_bus_idle", bus_idle, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        s0 = sof_cnt;
        n = dv_t.size();
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        sample_en = 1'b0;
        te = n;
        wait_idle(1500, n);
        check("midrst_idle_window", (n >= 1000 && n <= 1200), 1'b1);
        check("midrst_no_sof", sof_cnt - s0, 0);
        check("midrst_no_dvalid", dv_t.size() - te, 0);
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
